// File: rtl/eth_tx_scheduler.sv
// Ethernet transmit scheduler: arbitrates a per-frame player-state snapshot against
// on-demand game events, launches the RMII transmitter, then waits (with watchdog) and enforces the IFG.
module eth_tx_scheduler #(
  parameter int H_TRIG     = 1024,
  parameter int V_TRIG     = 768,
  parameter int FRAME_DIV  = 1,
  parameter int IFG_CYCLES = 48,
  parameter int TIMEOUT    = 4096
) (
  input  logic        eth_clk,
  input  logic        eth_rst,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic [10:0] player_x,
  input  logic [10:0] player_y,
  input  logic [8:0]  direction,
  input  logic [2:0]  game_stat,
  input  logic        evt_req,
  input  logic [15:0] evt_data,
  output logic        evt_ack,
  output logic        tx_start,
  output logic [39:0] tx_payload,
  input  logic        tx_done,
  output logic        sched_busy,
  output logic [7:0]  drop_count,
  output logic        err_timeout
);
  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam int GCW = $clog2(IFG_CYCLES + 1);
  localparam logic [10:0]    H_MATCH    = 11'(H_TRIG);
  localparam logic [9:0]     V_MATCH    = 10'(V_TRIG);
  localparam logic [7:0]     FRAME_LAST = 8'(FRAME_DIV - 1);
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'(TIMEOUT - 1);
  localparam logic [GCW-1:0] GAP_LAST   = GCW'(IFG_CYCLES - 1);

  // Handshake: evt_req is held with stable evt_data until the one-cycle evt_ack,
  // which coincides with tx_start; tx_done is a one-cycle pulse honoured only in S_WAIT.
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GAP} state_t;
  state_t state;

  logic           hit, hit_q, trig, take;
  logic [7:0]     frame_cnt;
  logic [33:0]    snap;
  logic           state_pending;
  logic           last_evt;
  logic           grant_state, grant_evt;
  logic [3:0]     seq;
  logic [WCW-1:0] wait_cnt;
  logic [GCW-1:0] gap_cnt;

  assign hit  = (hcount == H_MATCH) && (vcount == V_MATCH);
  assign trig = hit && !hit_q;
  assign take = trig && (frame_cnt == 8'd0);

  // Round-robin only matters on a tie; last_evt resets to 1 so state wins the first tie.
  always_comb begin
    grant_state = 1'b0;
    grant_evt   = 1'b0;
    if (state == S_IDLE) begin
      if (state_pending && evt_req) begin
        grant_state = last_evt;
        grant_evt   = !last_evt;
      end else begin
        grant_state = state_pending;
        grant_evt   = evt_req;
      end
    end
  end

  always_ff @(posedge eth_clk or posedge eth_rst) begin
    if (eth_rst) begin
      hit_q         <= 1'b0;
      frame_cnt     <= 8'd0;
      snap          <= 34'd0;
      state_pending <= 1'b0;
      drop_count    <= 8'd0;
    end else begin
      hit_q <= hit;
      if (trig) frame_cnt <= (frame_cnt == FRAME_LAST) ? 8'd0 : frame_cnt + 8'd1;
      // A snapshot landing on the state grant refills the slot without counting a drop.
      if (take) begin
        snap          <= {player_x, player_y, direction, game_stat};
        state_pending <= 1'b1;
        if (state_pending && !grant_state && drop_count != 8'hFF)
          drop_count <= drop_count + 8'd1;
      end else if (grant_state) begin
        state_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge eth_clk or posedge eth_rst) begin
    if (eth_rst) begin
      state       <= S_IDLE;
      tx_start    <= 1'b0;
      evt_ack     <= 1'b0;
      tx_payload  <= 40'd0;
      seq         <= 4'd0;
      last_evt    <= 1'b1;
      wait_cnt    <= '0;
      gap_cnt     <= '0;
      sched_busy  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      evt_ack  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_state || grant_evt) begin
            tx_start   <= 1'b1;
            evt_ack    <= grant_evt;
            tx_payload <= grant_state ? {2'b01, seq, snap} : {2'b10, seq, 18'd0, evt_data};
            seq        <= seq + 4'd1;
            last_evt   <= grant_evt;
            wait_cnt   <= '0;
            sched_busy <= 1'b1;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (tx_done) begin
            gap_cnt <= '0;
            state   <= S_GAP;
          end else if (wait_cnt == WAIT_LAST) begin
            err_timeout <= 1'b1;
            gap_cnt     <= '0;
            state       <= S_GAP;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            sched_busy <= 1'b0;
            state      <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GCW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/eth_tx_scheduler.md
# eth_tx_scheduler

Sequences the Ethernet transmit datapath on the eth_clk domain. Two packet sources share the single RMII transmitter:
- a periodic player-state snapshot, taken at a video-frame trigger point;
- an on-demand game-event request.

The block arbitrates between the two sources, builds a tagged 40-bit payload, launches the transmitter, waits for completion with a watchdog, and enforces the inter-frame gap before the next launch.

## Interface
Parameters:
- H_TRIG, 1024: hcount value that marks the snapshot point.
- V_TRIG, 768: vcount value that marks the snapshot point.
- FRAME_DIV, 1: take a snapshot every FRAME_DIV trigger points (1..255).
- IFG_CYCLES, 48: idle cycles after each packet (96 bit-times at 2 bits/cycle).
- TIMEOUT, 4096: maximum number of WAIT cycles before the packet is aborted.

Ports:
- eth_clk  in  1: 50 MHz RMII clock; the only clock.
- eth_rst  in  1: reset, asynchronous and active-high.
- hcount  in  11, vcount  in  10: pixel counters, already synchronised into eth_clk.
- player_x  in  11, player_y  in  11, direction  in  9, game_stat  in  3: player state.
- evt_req  in  1: event request. Held high until evt_ack.
- evt_data  in  16: event body. Held stable while evt_req is high.
- evt_ack  out  1: one-cycle pulse; evt_data has been captured.
- tx_start  out  1: one-cycle launch pulse to the transmitter.
- tx_payload  out  40: packet payload. Stable from tx_start until the block leaves WAIT.
- tx_done  in  1: one-cycle pulse from the transmitter when the packet is finished.
- sched_busy  out  1: high in WAIT and GAP.
- drop_count  out  8: number of overwritten, unsent snapshots. Saturates at 255.
- err_timeout  out  1: sticky flag, set on watchdog abort.

## Operation
Trigger detection:
- hit = (hcount==H_TRIG && vcount==V_TRIG).
- Trigger = rising edge of hit (hit now, not hit on the previous cycle). Holding the counters at the trigger point therefore fires only once.
- An 8-bit frame_cnt counts triggers modulo FRAME_DIV. A snapshot is taken on the trigger where frame_cnt==0.

Snapshot:
- Registers snap = {player_x, player_y, direction, game_stat} (34 bits) and sets state_pending.
- If state_pending is already set, the new snapshot overwrites the old one and drop_count increments (saturating).
- Exception: if the snapshot coincides with the cycle in which the state packet is granted, the granted packet uses the old snap, the new snap is stored, state_pending stays 1, and there is no drop.

Payload format:
- [39:38] type: 01 = state, 10 = event.
- [37:34] seq: 4-bit, increments per launch, wraps 15→0.
- [33:0] body: snap, or {18'b0, evt_data}.

FSM states: IDLE, WAIT, GAP.
- IDLE:
  - If state_pending or evt_req is set: grant one source, register tx_payload, pulse tx_start, increment seq, then go to WAIT.
  - State grant clears state_pending. Event grant pulses evt_ack in the same cycle as tx_start.
  - When both sources are pending, grant goes round-robin against last_grant. Reset value of last_grant is "event", so state wins the first tie.
- WAIT:
  - A wait counter increments each cycle.
  - tx_done → GAP.
  - Counter reaching TIMEOUT with no tx_done → set err_timeout, go to GAP.
  - tx_done in the same cycle as the timeout counts as done: no error.
- GAP: hold for exactly IFG_CYCLES cycles, then go to IDLE. tx_done arriving in IDLE or GAP is ignored.

## Timing
- Reset values: every output is 0 (tx_payload, drop_count and err_timeout included). seq=0, frame_cnt=0, state_pending=0, FSM in IDLE.
- Reset asserted mid-packet aborts immediately. No evt_ack is issued for the aborted packet.
- Request sampled at edge k in IDLE → tx_start (and evt_ack, for an event) high during cycle k+1 only.
- A trigger at edge k makes state_pending visible at edge k+1. The earliest tx_start is then cycle k+2.
- tx_done sampled at edge d → GAP occupies cycles d+1 .. d+IFG_CYCLES. The earliest next tx_start is cycle d+IFG_CYCLES+2.
- Throughput is one packet per launch + transmit + IFG_CYCLES + 1 cycles.

## Test plan
- Reset, then player_x=8, player_y=8, direction=90, game_stat=1, counters stepped 0,0 → 1024,768. Expect one tx_start with tx_payload={2'b01, 4'd0, 11'd8, 11'd8, 9'd90, 3'd1}. Holding 1024,768 for 100 cycles produces no second trigger.
- evt_req=1, evt_data=16'hBEEF in IDLE. Expect evt_ack and tx_start in the same cycle, tx_payload={2'b10, seq, 18'b0, 16'hBEEF}. Return tx_done 200 cycles later; sched_busy falls exactly 48 cycles after tx_done.
- Event and snapshot pending together over three packets. Expect grant order state, event, state (round-robin), with seq 0, 1, 2.
- Withhold tx_done. Expect err_timeout=1 after 4096 WAIT cycles, a GAP, then service of the next pending request. err_timeout stays 1 until eth_rst.
- Three triggers while stuck in WAIT. Expect drop_count=2 and the last snapshot sent. With FRAME_DIV=3, only every third trigger sets state_pending.
- Assert eth_rst during WAIT with evt_req held. Expect all outputs 0 immediately. After release the event is re-served with seq=0.
